// File: rtl/sm_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sm_accumulator
// Brief    : Streaming sign-magnitude accumulator. Sums one packet of terms
//            arriving over valid/ready, then presents a single registered
//            result with an overflow flag and a term count.
// Revision : 1.0 - initial release
// ============================================================================
module sm_accumulator #(
  parameter int WIDTH    = 21,
  parameter int GUARD    = 4,
  parameter int SATURATE = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_count
);

  localparam int MAG = WIDTH - 1;
  localparam int ACC_W = MAG + GUARD;
  // Largest magnitude representable at the output, widened to accumulator size.
  localparam logic [ACC_W-1:0] C_MAG_LIMIT = (ACC_W'(1) << MAG) - ACC_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_sign;
  logic [ACC_W-1:0] r_mag;
  logic             r_ovf;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_sat;
  logic [CNT_W-1:0] r_out_count;

  logic             w_accept;
  logic [ACC_W-1:0] w_term_mag;
  logic             w_term_sign;
  logic [ACC_W:0]   w_sum;
  logic             w_acc_sign;
  logic [ACC_W-1:0] w_acc_mag;
  logic             w_acc_ovf;
  logic             w_ovf_out;
  logic [MAG-1:0]   w_out_mag;
  logic             w_out_sign;
  logic [CNT_W-1:0] w_count_nxt;

  assign in_ready  = (r_state != HOLD);
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_count = r_out_count;

  assign w_accept    = in_valid & in_ready;
  // A negative zero term is folded to +0 so it can never flip the sign.
  assign w_term_mag  = ACC_W'(in_data[MAG-1:0]);
  assign w_term_sign = in_data[WIDTH-1] & (|in_data[MAG-1:0]);
  assign w_sum       = {1'b0, r_mag} + {1'b0, w_term_mag};
  assign w_count_nxt = r_count + CNT_W'(1);

  // Sign-magnitude add of the incoming term into the running accumulator.
  always_comb begin
    w_acc_sign = r_sign;
    w_acc_mag  = r_mag;
    w_acc_ovf  = r_ovf;
    if (r_sign == w_term_sign) begin
      if (w_sum[ACC_W]) begin
        w_acc_mag = '1;
        w_acc_ovf = 1'b1;
      end else begin
        w_acc_mag = w_sum[ACC_W-1:0];
      end
    end else if (r_mag >= w_term_mag) begin
      w_acc_mag = r_mag - w_term_mag;
    end else begin
      w_acc_mag  = w_term_mag - r_mag;
      w_acc_sign = w_term_sign;
    end
    // Keep the accumulator free of -0.
    if (w_acc_mag == '0) begin
      w_acc_sign = 1'b0;
    end
  end

  assign w_ovf_out = w_acc_ovf | (w_acc_mag > C_MAG_LIMIT);

  generate
    if (SATURATE != 0) begin : g_sat
      assign w_out_mag = w_ovf_out ? {MAG{1'b1}} : w_acc_mag[MAG-1:0];
    end else begin : g_trunc
      assign w_out_mag = w_acc_mag[MAG-1:0];
    end
  endgenerate

  // Truncation can produce a zero magnitude; the result sign then reads +0.
  assign w_out_sign = w_acc_sign & (|w_out_mag);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: packet in, result out, clr aborts from anywhere.
  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            w_state_nxt = in_last ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Accumulator, counter and output registers; result captured on the last term.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign      <= 1'b0;
      r_mag       <= '0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_count <= '0;
    end else if (clr) begin
      r_sign  <= 1'b0;
      r_mag   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else if (r_state == HOLD) begin
      if (out_ready) begin
        r_sign  <= 1'b0;
        r_mag   <= '0;
        r_ovf   <= 1'b0;
        r_count <= '0;
      end
    end else if (w_accept) begin
      r_sign  <= w_acc_sign;
      r_mag   <= w_acc_mag;
      r_ovf   <= w_acc_ovf;
      r_count <= w_count_nxt;
      if (in_last) begin
        r_out_data  <= {w_out_sign, w_out_mag};
        r_out_sat   <= w_ovf_out;
        r_out_count <= w_count_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sm_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_accumulator
// Brief    : Directed self-checking bench for sm_accumulator. A saturating and
//            a truncating instance share the same input stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [20:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready,  in_ready_t;
  logic        out_valid, out_valid_t;
  logic [20:0] out_data,  out_data_t;
  logic        out_sat,   out_sat_t;
  logic [7:0]  out_count, out_count_t;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  sm_accumulator #(.WIDTH(21), .GUARD(4), .SATURATE(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .out_count(out_count)
  );

  sm_accumulator #(.WIDTH(21), .GUARD(4), .SATURATE(0), .CNT_W(8)) dut_t (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready_t), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_t), .out_ready(out_ready), .out_data(out_data_t),
    .out_sat(out_sat_t), .out_count(out_count_t)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one term and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [20:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      total_cnt++;
      fail_cnt++;
      $error("FAIL send_timeout: observed=in_ready_low expected=accept");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Complete the output handshake of a HOLD result.
  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset values while rst is held.
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_out_sat",   32'(out_sat),   32'h0);
    chk("rst_out_count", 32'(out_count), 32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // +5, -3, +7 -> +9
    send(21'h000005, 1'b0);
    send(21'h100003, 1'b0);
    chk("mix_not_yet_valid", 32'(out_valid), 32'h0);
    send(21'h000007, 1'b1);
    chk("mix_valid", 32'(out_valid), 32'h1);
    chk("mix_data",  32'(out_data),  32'h000009);
    chk("mix_sat",   32'(out_sat),   32'h0);
    chk("mix_count", 32'(out_count), 32'h3);
    chk("mix_in_ready_hold", 32'(in_ready), 32'h0);
    drain();
    chk("mix_released", 32'(out_valid), 32'h0);

    // +3, -3 -> +0
    send(21'h000003, 1'b0);
    send(21'h100003, 1'b1);
    chk("cancel_data",  32'(out_data),  32'h000000);
    chk("cancel_count", 32'(out_count), 32'h2);
    drain();

    // single -0 -> +0
    send(21'h100000, 1'b1);
    chk("negzero_valid", 32'(out_valid), 32'h1);
    chk("negzero_data",  32'(out_data),  32'h000000);
    chk("negzero_count", 32'(out_count), 32'h1);
    drain();

    // 0x0FFFFF + 1 overflows 20 bits
    send(21'h0FFFFF, 1'b0);
    send(21'h000001, 1'b1);
    chk("ovf_sat_data",    32'(out_data),   32'h0FFFFF);
    chk("ovf_sat_flag",    32'(out_sat),    32'h1);
    chk("ovf_trunc_data",  32'(out_data_t), 32'h000000);
    chk("ovf_trunc_flag",  32'(out_sat_t),  32'h1);
    chk("ovf_trunc_valid", 32'(out_valid_t), 32'h1);
    drain();

    // -0x10 + 4 -> -0x0C
    send(21'h100010, 1'b0);
    send(21'h000004, 1'b1);
    chk("neg_data",  32'(out_data),  32'h10000C);
    chk("neg_count", 32'(out_count), 32'h2);
    chk("neg_trunc_data", 32'(out_data_t), 32'h10000C);
    drain();

    // Backpressure: result held while input pulses are ignored.
    out_ready = 1'b0;
    send(21'h000006, 1'b1);
    for (int i = 0; i < 3; i++) begin
      in_valid = (i != 1);
      in_data  = 21'h000007;
      in_last  = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid",    32'(out_valid), 32'h1);
      chk("bp_data",     32'(out_data),  32'h000006);
      chk("bp_in_ready", 32'(in_ready),  32'h0);
      chk("bp_count",    32'(out_count), 32'h1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    // Handshake and a waiting term coincide; the term lands one cycle later.
    out_ready = 1'b1;
    send(21'h000001, 1'b1);
    chk("bp_next_data",  32'(out_data),  32'h000001);
    chk("bp_next_count", 32'(out_count), 32'h1);
    drain();

    // Abort after 2 of 4 terms; the term presented with clr is dropped.
    send(21'h000009, 1'b0);
    send(21'h000009, 1'b0);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 21'h000009;
    @(posedge clk); #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_valid", 32'(out_valid), 32'h0);
    chk("clr_in_ready",  32'(in_ready),  32'h1);
    send(21'h000002, 1'b1);
    chk("clr_data",  32'(out_data),  32'h000002);
    chk("clr_count", 32'(out_count), 32'h1);
    drain();

    // clr while a result is pending discards it.
    out_ready = 1'b0;
    send(21'h000004, 1'b1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_hold_valid", 32'(out_valid), 32'h0);
    out_ready = 1'b1;
    send(21'h000003, 1'b1);
    chk("clr_hold_next", 32'(out_data), 32'h000003);
    chk("clr_hold_next_count", 32'(out_count), 32'h1);
    drain();

    // Asynchronous reset in the middle of HOLD.
    out_ready = 1'b0;
    send(21'h000005, 1'b1);
    chk("arst_pre_valid", 32'(out_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_data",  32'(out_data),  32'h0);
    chk("arst_count", 32'(out_count), 32'h0);
    chk("arst_ready", 32'(in_ready),  32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(21'h100002, 1'b1);
    chk("post_rst_data", 32'(out_data), 32'h100002);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
